// File: rtl/queue_write_arbiter_if.sv
// Write-side bundle shared by the packet sources, the arbiter and Packet_Queue.
// Sources and the queue drive the master side; the arbiter is the slave.
interface queue_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       Req;
  logic [N_REQ*WIDTH-1:0] Pkt;
  logic                   Full;
  logic [N_REQ-1:0]       Gnt;
  logic [WIDTH-1:0]       Packet_In;
  logic                   Write_Ack;
  logic                   Busy;
  logic [15:0]            Wr_Count;

  modport master (
    output Req, Pkt, Full,
    input  Gnt, Packet_In, Write_Ack, Busy, Wr_Count
  );

  modport slave (
    input  Req, Pkt, Full,
    output Gnt, Packet_In, Write_Ack, Busy, Wr_Count
  );
endinterface

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter sharing one Packet_Queue write port, one write per 3 cycles.
// Define QARB_PRIO0_EN to give requester 0 absolute priority over the rotation.
module queue_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input logic                 Clk_r,
  input logic                 Rst,
  queue_write_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    nxt_ptr;
  logic [N_REQ-1:0] cand;
  logic             found;
  logic             upd_ptr;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] pkt_q;
  logic             ack;
  logic [15:0]      cnt;
  int               idx;

  always_comb begin
    cand    = bus.Req;
    found   = 1'b0;
    winner  = '0;
    upd_ptr = 1'b1;
    idx     = 0;
`ifdef QARB_PRIO0_EN
    // Source 0 bypasses the rotation and leaves rr_ptr untouched.
    cand[0] = 1'b0;
    if (bus.Req[0]) begin
      found   = 1'b1;
      upd_ptr = 1'b0;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign nxt_ptr = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

  always_ff @(posedge Clk_r) begin
    if (Rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      ack    <= 1'b0;
      pkt_q  <= '0;
      cnt    <= '0;
    end else begin
      gnt <= '0;
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && !bus.Full) begin
            gnt         <= '0;
            gnt[winner] <= 1'b1;
            ack         <= 1'b1;
            pkt_q       <= bus.Pkt[int'(winner)*WIDTH +: WIDTH];
            cnt         <= cnt + 16'd1;
            if (upd_ptr) rr_ptr <= nxt_ptr;
            state       <= WRITE;
          end
        end
        WRITE:   state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Gnt       = gnt;
  assign bus.Write_Ack = ack;
  assign bus.Packet_In = pkt_q;
  assign bus.Wr_Count  = cnt;
  assign bus.Busy      = (state != IDLE);
endmodule

// File: tb/tb_queue_write_arbiter.sv
// Bench for queue_write_arbiter: vector table, directed sequences, random run.
// Reference model tracks slot occupancy, a pointer and a write count.
module tb_queue_write_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  queue_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

  queue_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .Clk_r(clk),
    .Rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] pk [N];
  int checks = 0;
  int errors = 0;

  int          m_slot = 3;
  int          m_ptr  = 0;
  int          m_cnt  = 0;
  logic [N-1:0] e_gnt;
  logic        e_ack;
  logic [31:0] e_pkt = '0;

  int          gq[$];
  int          pq[$];

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic        full;
    logic [3:0]  gnt;
    logic        ack;
    logic [31:0] pkt;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [3:0] req, logic full,
                              logic [3:0] gnt, logic ack, logic [31:0] pkt,
                              logic busy, logic [15:0] cnt);
    vec_t v;
    v.r = r; v.req = req; v.full = full; v.gnt = gnt;
    v.ack = ack; v.pkt = pkt; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef QARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
`ifdef QARB_PRIO0_EN
      if (i == 0) continue;
`endif
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // A new grant is allowed once three cycles have passed since the last one.
  task automatic model_step();
    int w;
    e_gnt = '0;
    e_ack = 1'b0;
    if (rst) begin
      m_slot = 3; m_ptr = 0; m_cnt = 0; e_pkt = '0;
    end else if (m_slot >= 3 && !bus.Full && bus.Req != '0) begin
      w        = pick(bus.Req);
      e_gnt[w] = 1'b1;
      e_ack    = 1'b1;
      e_pkt    = pk[w];
      m_cnt    = (m_cnt + 1) % 65536;
`ifdef QARB_PRIO0_EN
      if (w != 0) m_ptr = (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
`endif
      m_slot = 1;
    end else if (m_slot < 3) begin
      m_slot++;
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] q, input logic f);
    rst     = r;
    bus.Req = q;
    bus.Full = f;
    bus.Pkt = {pk[3], pk[2], pk[1], pk[0]};
    model_step();
    @(posedge clk);
    #1;
    chk("gnt",  32'(bus.Gnt), 32'(e_gnt));
    chk("ack",  32'(bus.Write_Ack), 32'(e_ack));
    chk("pkt",  bus.Packet_In, e_pkt);
    chk("busy", 32'(bus.Busy), 32'(m_slot < 3));
    chk("cnt",  32'(bus.Wr_Count), 32'(m_cnt));
    for (int i = 0; i < N; i++)
      if (bus.Gnt[i]) begin
        gq.push_back(i);
        pq.push_back(int'(bus.Packet_In));
      end
  endtask

  initial begin : main
    int exp_ord[5];
    int exp_pk[5];
    int vals[$];
    int fifo[$];
    int acks;
    logic [N-1:0] rq;

    bus.Req = '0; bus.Full = 1'b0; bus.Pkt = '0;

    // Table: single source, full back-pressure, release.
    pk[0] = 32'd6; pk[1] = 32'd5; pk[2] = 32'd8; pk[3] = 32'd9;
    tv.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
    tv.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 5, 1, 1));
    tv.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 5, 1, 1));
    tv.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 5, 0, 1));
    for (int i = 0; i < 10; i++)
      tv.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 5, 0, 1));
    tv.push_back(mk(0, 4'b0100, 0, 4'b0100, 1, 8, 1, 2));
    tv.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 8, 1, 2));
    tv.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 8, 0, 2));
    foreach (tv[i]) begin
      cyc(tv[i].r, tv[i].req, tv[i].full);
      chk("tv_gnt",  32'(bus.Gnt), 32'(tv[i].gnt));
      chk("tv_ack",  32'(bus.Write_Ack), 32'(tv[i].ack));
      chk("tv_pkt",  bus.Packet_In, tv[i].pkt);
      chk("tv_busy", 32'(bus.Busy), 32'(tv[i].busy));
      chk("tv_cnt",  32'(bus.Wr_Count), 32'(tv[i].cnt));
    end

    // Fairness with all requests held.
    for (int i = 0; i < N; i++) pk[i] = 32'(6 + i);
    cyc(1, '0, 0);
    gq.delete(); pq.delete();
    for (int c = 0; c < 15; c++) cyc(0, 4'b1111, 0);
`ifdef QARB_PRIO0_EN
    exp_ord = '{0, 0, 0, 0, 0};
    exp_pk  = '{6, 6, 6, 6, 6};
`else
    exp_ord = '{0, 1, 2, 3, 0};
    exp_pk  = '{6, 7, 8, 9, 6};
`endif
    chk("rr_grants", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk("rr_order", 32'(gq[i]), 32'(exp_ord[i]));
      chk("rr_pkt",   32'(pq[i]), 32'(exp_pk[i]));
    end

    // Reset asserted during WRITE.
    cyc(0, 4'b1111, 0);
    chk("pre_rst_ack", 32'(bus.Write_Ack), 32'd1);
    cyc(1, 4'b1111, 0);
    chk("rst_ack", 32'(bus.Write_Ack), 32'd0);
    chk("rst_gnt", 32'(bus.Gnt), 32'd0);
    chk("rst_cnt", 32'(bus.Wr_Count), 32'd0);
    cyc(0, 4'b1111, 0);
    chk("rst_next_gnt", 32'(bus.Gnt), 32'b0001);

`ifdef QARB_PRIO0_EN
    cyc(1, '0, 0);
    gq.delete(); pq.delete();
    for (int c = 0; c < 9; c++) cyc(0, 4'b1111, 0);
    for (int c = 0; c < 9; c++) cyc(0, 4'b1110, 0);
    exp_ord = '{0, 0, 0, 1, 2};
    chk("prio_grants", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk("prio_order", 32'(gq[i]), 32'(exp_ord[i]));
    if (gq.size() > 5) chk("prio_last", 32'(gq[5]), 32'd3);
`endif

    // Paired with a depth-5 queue until it fills.
    cyc(1, '0, 0);
    pk[0] = 32'd0; pk[1] = 32'd5; pk[2] = 32'd6; pk[3] = 32'd7;
    vals = '{8, 9};
    rq = 4'b1110;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(0, rq, fifo.size() >= 5);
      if (bus.Write_Ack) begin
        fifo.push_back(int'(bus.Packet_In));
        acks++;
      end
      for (int i = 0; i < N; i++)
        if (bus.Gnt[i]) begin
          if (vals.size() > 0) pk[i] = 32'(vals.pop_front());
          else rq[i] = 1'b0;
        end
      if (fifo.size() >= 5 && !rq[0]) begin
        pk[0] = 32'd10;
        rq[0] = 1'b1;
      end
    end
    chk("q_writes", 32'(acks), 32'd5);
    chk("q_sixth_blocked", 32'(rq[0]), 32'd1);
    cyc(0, '0, 1);
    for (int k = 0; k < 5; k++)
      if (fifo.size() > 0) chk("q_read", 32'(fifo.pop_front()), 32'(5 + k));
      else chk("q_read_missing", 32'd0, 32'(5 + k));
    chk("q_empty", 32'(fifo.size()), 32'd0);

    // Random traffic against the model.
    cyc(1, '0, 0);
    rq = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          pk[i] = $urandom;
        end
      cyc($urandom_range(0, 99) == 0, rq, $urandom_range(0, 3) == 0);
      rq = rq & ~bus.Gnt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
